// File: rtl/ervp_design_info_mport.sv
// ervp_design_info_mport: read-only design identification strings served to
// NUM_PORT APB slave ports through one shared, round-robin arbitrated lookup
// path. A stream window (select + auto-incrementing data register) lets
// software walk any string through a single address.
module ervp_design_info_mport #(
    parameter int NUM_PORT          = 2,
    parameter int BW_ADDR           = 32,
    parameter int BW_SUBOFFSET      = 8,
    parameter int NUM_CHAR_PLATFORM = 16,
    parameter int NUM_CHAR_USER     = 16,
    parameter int NUM_CHAR_GITNAME  = 16,
    parameter int NUM_CHAR_GITVER   = 8,
    parameter int NUM_CHAR_DEVVER   = 8,
    parameter int NUM_CHAR_DATE     = 20,
    parameter int BYTE0_FIRST_CHAR  = 1
) (
    input  logic                           clk,
    input  logic                           rstnn,
    input  logic [NUM_PORT-1:0]            rpsel,
    input  logic [NUM_PORT-1:0]            rpenable,
    input  logic [NUM_PORT*BW_ADDR-1:0]    rpaddr,
    input  logic [NUM_PORT-1:0]            rpwrite,
    input  logic [NUM_PORT*32-1:0]         rpwdata,
    output logic [NUM_PORT*32-1:0]         rprdata,
    output logic [NUM_PORT-1:0]            rpready,
    output logic [NUM_PORT-1:0]            rpslverr,
    input  logic [NUM_CHAR_PLATFORM*8-1:0] str_platform,
    input  logic [NUM_CHAR_USER*8-1:0]     str_user,
    input  logic [NUM_CHAR_GITNAME*8-1:0]  str_gitname,
    input  logic [NUM_CHAR_GITVER*8-1:0]   str_gitver,
    input  logic [NUM_CHAR_DEVVER*8-1:0]   str_devver,
    input  logic [NUM_CHAR_DATE*8-1:0]     str_date
);

    localparam int BW_PORT = (NUM_PORT > 1) ? $clog2(NUM_PORT) : 1;
    localparam logic [BW_SUBOFFSET-1:0] OFF_SEL  = BW_SUBOFFSET'('hC0);
    localparam logic [BW_SUBOFFSET-1:0] OFF_DATA = BW_SUBOFFSET'('hC4);
    localparam logic [BW_SUBOFFSET-1:0] OFF_PTR  = BW_SUBOFFSET'('hC8);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_RESP
    } state_t;

    state_t                  state;
    logic [BW_PORT-1:0]      grant;
    logic [BW_PORT-1:0]      last_grant;
    logic [BW_SUBOFFSET-1:0] lat_off;
    logic                    lat_write;
    logic [31:0]             lat_wdata;
    logic [2:0]              sel;
    logic [4:0]              ptr;

    logic [NUM_PORT-1:0]     req;
    logic                    any_req;
    logic [BW_PORT-1:0]      next_grant;

    logic [255:0]            field_str [8];
    logic [2:0]              acc_field;
    logic [2:0]              acc_word;
    logic [31:0]             field_word;
    logic [31:0]             stream_word;
    logic [31:0]             lookup_data;
    logic                    lookup_err;
    logic                    sel_write;
    logic                    ptr_step;
    logic [4:0]              ptr_next;

    // Upper address bits beyond the decoded window are intentionally ignored.
    logic unused_bits;
    assign unused_bits = ^{rpaddr, rpwdata};

    // Number of 32-bit words in each field, in field order.
    function automatic logic [3:0] words_of(input logic [2:0] f);
        case (f)
            3'd0:    words_of = 4'(NUM_CHAR_PLATFORM / 4);
            3'd1:    words_of = 4'(NUM_CHAR_USER / 4);
            3'd2:    words_of = 4'(NUM_CHAR_GITNAME / 4);
            3'd3:    words_of = 4'(NUM_CHAR_GITVER / 4);
            3'd4:    words_of = 4'(NUM_CHAR_DEVVER / 4);
            3'd5:    words_of = 4'(NUM_CHAR_DATE / 4);
            default: words_of = 4'd0;
        endcase
    endfunction

    // Word k of a left-aligned string, first char in the MSB byte.
    function automatic logic [31:0] pick_word(input logic [255:0] s, input logic [2:0] k);
        pick_word = s[255 - 32*int'(k) -: 32];
    endfunction

    // Place the first char of the word in byte 0 or byte 3.
    function automatic logic [31:0] order_word(input logic [31:0] w);
        if (BYTE0_FIRST_CHAR != 0) begin
            order_word = {w[7:0], w[15:8], w[23:16], w[31:24]};
        end else begin
            order_word = w;
        end
    endfunction

    // Left-align every string in a 256-bit slot so word k sits at a fixed position.
    always_comb begin
        field_str[0] = 256'(str_platform) << (256 - 8*NUM_CHAR_PLATFORM);
        field_str[1] = 256'(str_user)     << (256 - 8*NUM_CHAR_USER);
        field_str[2] = 256'(str_gitname)  << (256 - 8*NUM_CHAR_GITNAME);
        field_str[3] = 256'(str_gitver)   << (256 - 8*NUM_CHAR_GITVER);
        field_str[4] = 256'(str_devver)   << (256 - 8*NUM_CHAR_DEVVER);
        field_str[5] = 256'(str_date)     << (256 - 8*NUM_CHAR_DATE);
        field_str[6] = '0;
        field_str[7] = '0;
    end

    // A port in its response cycle must not be counted as a fresh request.
    assign req = rpsel & rpenable & ~rpready;

    // Round robin: first requester after the most recently served port.
    always_comb begin
        any_req    = 1'b0;
        next_grant = '0;
        for (int i = 1; i <= NUM_PORT; i++) begin
            if (!any_req && req[(int'(last_grant) + i) % NUM_PORT]) begin
                any_req    = 1'b1;
                next_grant = BW_PORT'((int'(last_grant) + i) % NUM_PORT);
            end
        end
    end

    // Decode the latched access into response data, error flag and side effects.
    always_comb begin
        acc_field   = lat_off[7:5];
        acc_word    = lat_off[4:2];
        field_word  = order_word(pick_word(field_str[acc_field], acc_word));
        stream_word = order_word(pick_word(field_str[sel], ptr[2:0]));
        if (ptr + 5'd1 >= {1'b0, words_of(sel)}) begin
            ptr_next = '0;
        end else begin
            ptr_next = ptr + 5'd1;
        end
        lookup_data = '0;
        lookup_err  = 1'b1;
        sel_write   = 1'b0;
        ptr_step    = 1'b0;
        if (lat_off[1:0] == 2'b00) begin
            if (lat_write) begin
                if (lat_off == OFF_SEL && lat_wdata < 32'd6) begin
                    lookup_err = 1'b0;
                    sel_write  = 1'b1;
                end
            end else if (lat_off < OFF_SEL) begin
                if ({1'b0, acc_word} < words_of(acc_field)) begin
                    lookup_data = field_word;
                    lookup_err  = 1'b0;
                end
            end else if (lat_off == OFF_SEL) begin
                lookup_data = {29'd0, sel};
                lookup_err  = 1'b0;
            end else if (lat_off == OFF_DATA) begin
                lookup_data = stream_word;
                lookup_err  = 1'b0;
                ptr_step    = 1'b1;
            end else if (lat_off == OFF_PTR) begin
                lookup_data = {27'd0, ptr};
                lookup_err  = 1'b0;
            end
        end
    end

    // Transaction FSM: grant and latch, look up, then a one-cycle response.
    always_ff @(posedge clk or negedge rstnn) begin
        if (!rstnn) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= BW_PORT'(NUM_PORT - 1);
            lat_off    <= '0;
            lat_write  <= 1'b0;
            lat_wdata  <= '0;
            sel        <= '0;
            ptr        <= '0;
            rprdata    <= '0;
            rpready    <= '0;
            rpslverr   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (any_req) begin
                        grant     <= next_grant;
                        lat_off   <= rpaddr[int'(next_grant)*BW_ADDR +: BW_SUBOFFSET];
                        lat_write <= rpwrite[next_grant];
                        lat_wdata <= rpwdata[int'(next_grant)*32 +: 32];
                        state     <= ST_LOOKUP;
                    end
                end
                ST_LOOKUP: begin
                    rprdata                      <= '0;
                    rprdata[int'(grant)*32 +: 32] <= lookup_data;
                    rpready                      <= '0;
                    rpready[grant]               <= 1'b1;
                    rpslverr                     <= '0;
                    rpslverr[grant]              <= lookup_err;
                    if (sel_write) begin
                        sel <= lat_wdata[2:0];
                        ptr <= '0;
                    end
                    if (ptr_step) begin
                        ptr <= ptr_next;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    rprdata    <= '0;
                    rpready    <= '0;
                    rpslverr   <= '0;
                    last_grant <= grant;
                    state      <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ervp_design_info_mport.sv
// tb_ervp_design_info_mport: table-driven directed vectors, contention and
// reset sequences, then randomized traffic against a string-level model.
module tb_ervp_design_info_mport;

    localparam int NUM_PORT = 2;

    localparam logic [16*8-1:0] S_PLATFORM = "ABCDEFGHIJKLMNOP";
    localparam logic [16*8-1:0] S_USER     = "alice_developer!";
    localparam logic [16*8-1:0] S_GITNAME  = "ervp_home_gitrep";
    localparam logic [8*8-1:0]  S_GITVER   = "v1.2.3-a";
    localparam logic [8*8-1:0]  S_DEVVER   = "dk-0.9.7";
    localparam logic [20*8-1:0] S_DATE     = "2025-07-15 12:00:00 ";

    logic                   clk;
    logic                   rstnn;
    logic [NUM_PORT-1:0]    rpsel;
    logic [NUM_PORT-1:0]    rpenable;
    logic [NUM_PORT*32-1:0] rpaddr;
    logic [NUM_PORT-1:0]    rpwrite;
    logic [NUM_PORT*32-1:0] rpwdata;
    logic [NUM_PORT*32-1:0] rprdata;
    logic [NUM_PORT-1:0]    rpready;
    logic [NUM_PORT-1:0]    rpslverr;
    logic [NUM_PORT*32-1:0] be_rprdata;
    logic [NUM_PORT-1:0]    be_rpready;
    logic [NUM_PORT-1:0]    be_rpslverr;

    int n_checks = 0;
    int n_fail   = 0;
    int bus_viol = 0;

    // Reference model state
    string mstr [6];
    int    nchar [6];
    int    m_sel;
    int    m_ptr;
    int    m_last;

    // Per-port request and response slots
    logic [31:0] q_addr  [NUM_PORT];
    bit          q_write [NUM_PORT];
    logic [31:0] q_wdata [NUM_PORT];
    logic [31:0] r_data  [NUM_PORT];
    logic [31:0] r_be    [NUM_PORT];
    bit          r_err   [NUM_PORT];
    int          r_lat   [NUM_PORT];
    logic [31:0] e_data  [NUM_PORT];
    logic [31:0] e_be    [NUM_PORT];
    bit          e_err   [NUM_PORT];

    typedef struct {
        int          port;
        logic [31:0] addr;
        bit          wr;
        logic [31:0] wdata;
        logic [31:0] exp_data;
        bit          exp_err;
    } vec_t;

    vec_t vecs [27];

    ervp_design_info_mport #(.NUM_PORT(NUM_PORT), .BYTE0_FIRST_CHAR(1)) dut (
        .clk(clk), .rstnn(rstnn),
        .rpsel(rpsel), .rpenable(rpenable), .rpaddr(rpaddr), .rpwrite(rpwrite), .rpwdata(rpwdata),
        .rprdata(rprdata), .rpready(rpready), .rpslverr(rpslverr),
        .str_platform(S_PLATFORM), .str_user(S_USER), .str_gitname(S_GITNAME),
        .str_gitver(S_GITVER), .str_devver(S_DEVVER), .str_date(S_DATE)
    );

    ervp_design_info_mport #(.NUM_PORT(NUM_PORT), .BYTE0_FIRST_CHAR(0)) dut_be (
        .clk(clk), .rstnn(rstnn),
        .rpsel(rpsel), .rpenable(rpenable), .rpaddr(rpaddr), .rpwrite(rpwrite), .rpwdata(rpwdata),
        .rprdata(be_rprdata), .rpready(be_rpready), .rpslverr(be_rpslverr),
        .str_platform(S_PLATFORM), .str_user(S_USER), .str_gitname(S_GITNAME),
        .str_gitver(S_GITVER), .str_devver(S_DEVVER), .str_date(S_DATE)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Word k of field f assembled from the string characters.
    function automatic logic [31:0] model_word(input int f, input int k, input bit be);
        logic [31:0] w;
        w = '0;
        for (int b = 0; b < 4; b++) begin
            logic [7:0] c;
            c = mstr[f][4*k + b];
            if (be) w = w | (32'(c) << (8*(3 - b)));
            else    w = w | (32'(c) << (8*b));
        end
        return w;
    endfunction

    // One access against the memory-map rules, applying its side effects.
    function automatic void model_access(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                                         output logic [31:0] d, output logic [31:0] db, output bit e);
        int off;
        off = int'(addr & 32'hFF);
        d = '0;
        db = '0;
        e = 1'b1;
        if (off % 4 != 0) return;
        if (wr) begin
            if (off == 'hC0 && wdata < 32'd6) begin
                m_sel = int'(wdata);
                m_ptr = 0;
                e = 1'b0;
            end
            return;
        end
        if (off < 'hC0) begin
            int f;
            int k;
            f = off / 32;
            k = (off % 32) / 4;
            if (k < nchar[f] / 4) begin
                d = model_word(f, k, 1'b0);
                db = model_word(f, k, 1'b1);
                e = 1'b0;
            end
        end else if (off == 'hC0) begin
            d = 32'(m_sel);
            db = 32'(m_sel);
            e = 1'b0;
        end else if (off == 'hC4) begin
            d = model_word(m_sel, m_ptr, 1'b0);
            db = model_word(m_sel, m_ptr, 1'b1);
            e = 1'b0;
            m_ptr = (m_ptr + 1) % (nchar[m_sel] / 4);
        end else if (off == 'hC8) begin
            d = 32'(m_ptr);
            db = 32'(m_ptr);
            e = 1'b0;
        end
    endfunction

    // Run APB transfers on every port in mask, starting them in the same cycle.
    task automatic applyStimulus(input logic [NUM_PORT-1:0] mask);
        logic [NUM_PORT-1:0] active;
        logic [NUM_PORT-1:0] done_now;
        int cyc;
        for (int p = 0; p < NUM_PORT; p++) begin
            r_data[p] = '0;
            r_be[p] = '0;
            r_err[p] = 1'b0;
            r_lat[p] = -1;
        end
        @(posedge clk); #1;
        for (int p = 0; p < NUM_PORT; p++) begin
            if (mask[p]) begin
                rpsel[p] = 1'b1;
                rpaddr[p*32 +: 32] = q_addr[p];
                rpwrite[p] = q_write[p];
                rpwdata[p*32 +: 32] = q_wdata[p];
            end
        end
        @(posedge clk); #1;
        for (int p = 0; p < NUM_PORT; p++) begin
            if (mask[p]) rpenable[p] = 1'b1;
        end
        active = mask;
        cyc = 0;
        while (active != '0 && cyc < 40) begin
            @(negedge clk);
            done_now = '0;
            for (int p = 0; p < NUM_PORT; p++) begin
                if (!rpready[p] && (rprdata[p*32 +: 32] != '0 || rpslverr[p])) bus_viol++;
                if (!be_rpready[p] && (be_rprdata[p*32 +: 32] != '0 || be_rpslverr[p])) bus_viol++;
                if (rpready[p] && !active[p]) bus_viol++;
                if (rpready[p] != be_rpready[p]) bus_viol++;
                if (active[p] && rpready[p]) begin
                    r_data[p] = rprdata[p*32 +: 32];
                    r_be[p] = be_rprdata[p*32 +: 32];
                    r_err[p] = rpslverr[p];
                    r_lat[p] = cyc;
                    done_now[p] = 1'b1;
                end
            end
            @(posedge clk); #1;
            for (int p = 0; p < NUM_PORT; p++) begin
                if (done_now[p]) begin
                    rpsel[p] = 1'b0;
                    rpenable[p] = 1'b0;
                    rpwrite[p] = 1'b0;
                    active[p] = 1'b0;
                end
            end
            cyc++;
        end
        if (active != '0) begin
            checkOutput("pready_timeout", 32'(active), 32'd0);
            rpsel = '0;
            rpenable = '0;
            rpwrite = '0;
        end
    endtask

    task automatic single(input int p, input logic [31:0] addr, input bit wr, input logic [31:0] wdata);
        q_addr[p] = addr;
        q_write[p] = wr;
        q_wdata[p] = wdata;
        model_access(addr, wr, wdata, e_data[p], e_be[p], e_err[p]);
        m_last = p;
        applyStimulus(NUM_PORT'(1) << p);
    endtask

    task automatic check_port(input string tag, input int p, input int exp_lat);
        checkOutput({tag, "_data"}, r_data[p], e_data[p]);
        checkOutput({tag, "_be"}, r_be[p], e_be[p]);
        checkOutput({tag, "_err"}, 32'(r_err[p]), 32'(e_err[p]));
        checkOutput({tag, "_lat"}, 32'(r_lat[p]), 32'(exp_lat));
    endtask

    task automatic gen_req(input int p);
        int kind;
        int off;
        logic [31:0] hi;
        kind = int'($urandom_range(0, 9));
        hi = $urandom() & 32'hFFFFFF00;
        case (kind)
            0, 1, 2: off = int'($urandom_range(0, 47)) * 4;
            3, 4:    off = 'hC4;
            5:       off = 'hC0 + int'($urandom_range(0, 2)) * 4;
            6:       off = int'($urandom_range(0, 255));
            default: off = 'hCC + int'($urandom_range(0, 12)) * 4;
        endcase
        q_write[p] = ($urandom_range(0, 4) == 0);
        if (q_write[p] && $urandom_range(0, 3) != 0) off = 'hC0;
        q_wdata[p] = ($urandom_range(0, 5) == 0) ? $urandom() : 32'($urandom_range(0, 7));
        q_addr[p] = hi | 32'(off);
    endtask

    initial begin
        logic [NUM_PORT-1:0] seen;
        logic [31:0] dd;
        logic [31:0] db;
        bit ee;

        mstr[0] = "ABCDEFGHIJKLMNOP";
        mstr[1] = "alice_developer!";
        mstr[2] = "ervp_home_gitrep";
        mstr[3] = "v1.2.3-a";
        mstr[4] = "dk-0.9.7";
        mstr[5] = "2025-07-15 12:00:00 ";
        nchar = '{16, 16, 16, 8, 8, 20};
        m_sel = 0;
        m_ptr = 0;
        m_last = NUM_PORT - 1;

        vecs[0]  = '{0, 32'h000, 1'b0, 32'h0,    32'h44434241, 1'b0};
        vecs[1]  = '{1, 32'h004, 1'b0, 32'h0,    32'h48474645, 1'b0};
        vecs[2]  = '{1, 32'h060, 1'b0, 32'h0,    32'h322E3176, 1'b0};
        vecs[3]  = '{0, 32'h0C0, 1'b1, 32'h5,    32'h0,        1'b0};
        vecs[4]  = '{0, 32'h0C0, 1'b0, 32'h0,    32'h5,        1'b0};
        vecs[5]  = '{0, 32'h0C4, 1'b0, 32'h0,    32'h35323032, 1'b0};
        vecs[6]  = '{1, 32'h0C4, 1'b0, 32'h0,    32'h2D37302D, 1'b0};
        vecs[7]  = '{0, 32'h0C4, 1'b0, 32'h0,    32'h31203531, 1'b0};
        vecs[8]  = '{1, 32'h0C4, 1'b0, 32'h0,    32'h30303A32, 1'b0};
        vecs[9]  = '{0, 32'h0C4, 1'b0, 32'h0,    32'h2030303A, 1'b0};
        vecs[10] = '{1, 32'h0C4, 1'b0, 32'h0,    32'h35323032, 1'b0};
        vecs[11] = '{1, 32'h0C8, 1'b0, 32'h0,    32'h1,        1'b0};
        vecs[12] = '{0, 32'h070, 1'b0, 32'h0,    32'h0,        1'b1};
        vecs[13] = '{0, 32'h002, 1'b0, 32'h0,    32'h0,        1'b1};
        vecs[14] = '{1, 32'h000, 1'b1, 32'h1234, 32'h0,        1'b1};
        vecs[15] = '{0, 32'h0C0, 1'b1, 32'h7,    32'h0,        1'b1};
        vecs[16] = '{0, 32'h0C0, 1'b0, 32'h0,    32'h5,        1'b0};
        vecs[17] = '{1, 32'h0CC, 1'b0, 32'h0,    32'h0,        1'b1};
        vecs[18] = '{0, 32'h0BC, 1'b0, 32'h0,    32'h0,        1'b1};
        vecs[19] = '{0, 32'h0C8, 1'b0, 32'h0,    32'h1,        1'b0};
        vecs[20] = '{1, 32'h0C0, 1'b1, 32'h1,    32'h0,        1'b0};
        vecs[21] = '{0, 32'h0C4, 1'b0, 32'h0,    32'h63696C61, 1'b0};
        vecs[22] = '{0, 32'h0C4, 1'b0, 32'h0,    32'h65645F65, 1'b0};
        vecs[23] = '{0, 32'h0C8, 1'b0, 32'h0,    32'h2,        1'b0};
        vecs[24] = '{1, 32'h10000004, 1'b0, 32'h0, 32'h48474645, 1'b0};
        vecs[25] = '{0, 32'h0C0, 1'b1, 32'h8,    32'h0,        1'b1};
        vecs[26] = '{0, 32'h0C0, 1'b0, 32'h0,    32'h1,        1'b0};

        rstnn = 1'b0;
        rpsel = '0;
        rpenable = '0;
        rpaddr = '0;
        rpwrite = '0;
        rpwdata = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset_pready", 32'(rpready), 32'd0);
        checkOutput("reset_prdata", rprdata, 32'd0);
        checkOutput("reset_pslverr", 32'(rpslverr), 32'd0);
        @(posedge clk); #1;
        rstnn = 1'b1;

        $display("[TB] directed vector table");
        for (int i = 0; i < 27; i++) begin
            single(vecs[i].port, vecs[i].addr, vecs[i].wr, vecs[i].wdata);
            checkOutput($sformatf("vec%0d_data", i), r_data[vecs[i].port], vecs[i].exp_data);
            checkOutput($sformatf("vec%0d_err", i), 32'(r_err[vecs[i].port]), 32'(vecs[i].exp_err));
            checkOutput($sformatf("vec%0d_lat", i), 32'(r_lat[vecs[i].port]), 32'd2);
        end

        $display("[TB] byte order of both instances");
        single(0, 32'h000, 1'b0, 32'h0);
        checkOutput("byte0_first", r_data[0], 32'h44434241);
        checkOutput("msb_first", r_be[0], 32'h41424344);

        $display("[TB] contention");
        single(1, 32'h008, 1'b0, 32'h0);
        check_port("pre_pair_p1", 1, 2);
        q_addr[0] = 32'h000; q_write[0] = 1'b0; q_wdata[0] = '0;
        q_addr[1] = 32'h004; q_write[1] = 1'b0; q_wdata[1] = '0;
        model_access(q_addr[0], 1'b0, 32'h0, e_data[0], e_be[0], e_err[0]);
        model_access(q_addr[1], 1'b0, 32'h0, e_data[1], e_be[1], e_err[1]);
        m_last = 1;
        applyStimulus(2'b11);
        checkOutput("pairA_p0_lat", 32'(r_lat[0]), 32'd2);
        checkOutput("pairA_p1_lat", 32'(r_lat[1]), 32'd5);
        checkOutput("pairA_p0_data", r_data[0], 32'h44434241);
        checkOutput("pairA_p1_data", r_data[1], 32'h48474645);
        single(0, 32'h00C, 1'b0, 32'h0);
        checkOutput("mid_p0_data", r_data[0], 32'h504F4E4D);
        model_access(q_addr[1], 1'b0, 32'h0, e_data[1], e_be[1], e_err[1]);
        model_access(q_addr[0], 1'b0, 32'h0, e_data[0], e_be[0], e_err[0]);
        m_last = 0;
        applyStimulus(2'b11);
        checkOutput("pairB_p1_lat", 32'(r_lat[1]), 32'd2);
        checkOutput("pairB_p0_lat", 32'(r_lat[0]), 32'd5);

        $display("[TB] reset during lookup");
        single(0, 32'h0C0, 1'b1, 32'h2);
        single(0, 32'h0C4, 1'b0, 32'h0);
        checkOutput("gitname_w0", r_data[0], 32'h70767265);
        @(posedge clk); #1;
        rpsel[0] = 1'b1; rpaddr[31:0] = 32'h0C4; rpwrite[0] = 1'b0;
        @(posedge clk); #1;
        rpenable[0] = 1'b1;
        @(posedge clk); #1;
        rstnn = 1'b0;
        #1;
        checkOutput("rst_mid_pready", 32'(rpready), 32'd0);
        rpsel = '0;
        rpenable = '0;
        @(posedge clk); #1;
        rstnn = 1'b1;
        m_sel = 0;
        m_ptr = 0;
        m_last = NUM_PORT - 1;
        seen = '0;
        repeat (4) begin
            @(negedge clk);
            seen = seen | rpready | be_rpready;
        end
        checkOutput("post_reset_quiet", 32'(seen), 32'd0);
        single(1, 32'h0C8, 1'b0, 32'h0);
        checkOutput("post_reset_ptr", r_data[1], 32'h0);
        single(1, 32'h0C0, 1'b0, 32'h0);
        checkOutput("post_reset_sel", r_data[1], 32'h0);
        single(1, 32'h0C4, 1'b0, 32'h0);
        checkOutput("post_reset_stream", r_data[1], 32'h44434241);

        $display("[TB] randomized traffic");
        for (int it = 0; it < 150; it++) begin
            gen_req(0);
            gen_req(1);
            if ($urandom_range(0, 9) < 3) begin
                int first;
                int second;
                first = (m_last + 1) % NUM_PORT;
                second = 1 - first;
                model_access(q_addr[first], q_write[first], q_wdata[first], e_data[first], e_be[first], e_err[first]);
                model_access(q_addr[second], q_write[second], q_wdata[second], e_data[second], e_be[second], e_err[second]);
                m_last = second;
                applyStimulus(2'b11);
                check_port($sformatf("rnd%0d_first", it), first, 2);
                check_port($sformatf("rnd%0d_second", it), second, 5);
            end else begin
                int p;
                p = int'($urandom_range(0, 1));
                model_access(q_addr[p], q_write[p], q_wdata[p], dd, db, ee);
                e_data[p] = dd;
                e_be[p] = db;
                e_err[p] = ee;
                m_last = p;
                applyStimulus(NUM_PORT'(1) << p);
                check_port($sformatf("rnd%0d_p%0d", it, p), p, 2);
            end
        end

        checkOutput("idle_bus_quiet", 32'(bus_viol), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/ervp_design_info_mport.md
Name: ervp_design_info_mport

Overview:
- Next-generation design-info slave for the platform controller: read-only design-identification strings served to NUM_PORT independent APB slave ports.
- Strings: platform name, username, home git name, home git version, devkit git version, design date.
- One shared lookup path with a round-robin arbiter and a registered response stage.
- Adds a stream window: a field-select register plus an auto-incrementing data register, so software can read any string through one address.

Parameters:
- NUM_PORT, 2, number of APB slave ports (1..8).
- BW_ADDR, 32, APB address width.
- BW_SUBOFFSET, 8, decoded low address bits; higher bits are ignored.
- NUM_CHAR_PLATFORM, 16, platform name length in chars (multiple of 4, at most 32). Same rule for NUM_CHAR_USER, NUM_CHAR_GITNAME, NUM_CHAR_GITVER, NUM_CHAR_DEVVER and NUM_CHAR_DATE.
- Defaults for the other lengths: NUM_CHAR_USER 16, NUM_CHAR_GITNAME 16, NUM_CHAR_GITVER 8, NUM_CHAR_DEVVER 8, NUM_CHAR_DATE 20.
- BYTE0_FIRST_CHAR, 1, when 1 the first char of each word goes in prdata[7:0]; when 0 it goes in prdata[31:24].

Ports:
- clk  in  1  clock.
- rstnn  in  1  asynchronous active-low reset.
- rpsel  in  NUM_PORT  per-port APB psel.
- rpenable  in  NUM_PORT  per-port penable.
- rpaddr  in  NUM_PORT*BW_ADDR  per-port paddr, port i in slice i.
- rpwrite  in  NUM_PORT  per-port pwrite.
- rpwdata  in  NUM_PORT*32  per-port pwdata.
- rprdata  out  NUM_PORT*32  per-port prdata.
- rpready  out  NUM_PORT  per-port pready.
- rpslverr  out  NUM_PORT  per-port pslverr.
- str_platform  in  NUM_CHAR_PLATFORM*8  string, first char in the MSB byte. Same packing for str_user, str_gitname, str_gitver, str_devver and str_date, each sized by its NUM_CHAR parameter.

Behaviour:
- Memory map, byte offsets within BW_SUBOFFSET:
  - Field f occupies 0x20*f + 4*k, word k, for k below NUM_CHAR_f/4.
  - Field order f: 0 platform, 1 user, 2 gitname, 3 gitver, 4 devver, 5 date.
  - 0x0C0 STREAM_SEL: RW, bits [2:0].
  - 0x0C4 STREAM_DATA: RO, auto-increment.
  - 0x0C8 STREAM_PTR: RO, {27'b0, ptr[4:0]}.
- Word packing: word k holds chars 4k..4k+3, positioned according to BYTE0_FIRST_CHAR.
- Request: port i requests while rpsel[i]&rpenable[i] and it is not in its response cycle.
- FSM IDLE -> LOOKUP -> RESP -> IDLE:
  - IDLE: if any request, grant the first requester after last_grant (round robin). Latch the granted port's addr, write and wdata. Go to LOOKUP.
  - LOOKUP: decode, register the response data/err, apply side effects. Go to RESP.
  - RESP: rpready[g]=1 for exactly one cycle, with rprdata slice g and rpslverr[g] driven. Update last_grant=g. Go to IDLE.
- Latency: penable rising in cycle T gives pready at T+2 minimum. A losing port holds pready=0 until granted; its maximum wait is NUM_PORT*3 cycles.
- Non-granted ports always see rpready=0, rprdata=0, rpslverr=0.
- Error response (pslverr=1, prdata=0, no side effect):
  - paddr[1:0]!=0.
  - Unmapped offset.
  - k at or beyond NUM_CHAR_f/4.
  - Write to anything except STREAM_SEL.
  - STREAM_SEL write value of 6 or more.
- STREAM_SEL write, value below 6: sel<=value, ptr<=0, pslverr=0.
- STREAM_DATA read: returns word ptr of field sel. Then ptr<=ptr+1, wrapping to 0 after the last word of field sel.
- STREAM_PTR and STREAM_SEL reads have no side effect.
- Simultaneous requests: only one is served per 3-cycle transaction. Side effects are strictly ordered by grant order.
- A requester dropping psel before pready is a protocol violation; the latched transaction still completes and its response is discarded.
- Reset, including mid-transaction:
  - FSM=IDLE, all outputs 0.
  - sel=0, ptr=0.
  - last_grant=NUM_PORT-1, so port 0 wins first after reset.
  - The in-flight transaction is dropped with no side effect.

Test Plan:
- Read, platform word 0: str_platform="ABCDEFGHIJKLMNOP", port 0 reads 0x000 -> pready at T+2, prdata=0x44434241, pslverr=0. With BYTE0_FIRST_CHAR=0 the same read returns 0x41424344.
- Stream walk of date: write STREAM_SEL=5, str_date="2025-07-15 12:00:00 ", then 6 reads of 0x0C4 -> words 0..4, then word 0 again. STREAM_PTR reads 1 after the 6th read.
- Contention: ports 0 and 1 raise penable in the same cycle -> port 0 gets pready at T+2, port 1 at T+5. Repeat with both -> port 1 is served first.
- Errors, each giving pslverr=1, prdata=0, STREAM_SEL unchanged:
  - Read 0x070 with NUM_CHAR_GITVER=8.
  - Read 0x002.
  - Write 0x000.
  - Write STREAM_SEL=7.
- Reset during LOOKUP of a STREAM_DATA read -> after reset, STREAM_PTR=0, STREAM_SEL=0, all pready=0 until a new request.
- Cross-port stream: port 1 writes STREAM_SEL=1, then port 0 reads STREAM_DATA twice -> username words 0 and 1 in order.
